// File: rtl/lcd_text_ctrl.sv
// rtl/lcd_text_ctrl.sv - HD44780-style character LCD controller with a ROWS x COLS text buffer
// Power-up wait, init command sequence, then endless row-by-row refresh from the buffer.
module lcd_text_ctrl #(
  parameter int POWERUP_CYCLES = 20000,
  parameter int SLOT_CYCLES    = 100000,
  parameter int COLS           = 16,
  parameter int ROWS           = 2,
  parameter int ADDR_W         = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  input  logic              clear,
  output logic              ready,
  output logic              init_done,
  output logic              lcd_e,
  output logic              lcd_rs,
  output logic [7:0]        lcd_data
);
  localparam int DEPTH = ROWS * COLS;
  localparam int PW_W  = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam int SL_W  = $clog2(SLOT_CYCLES);
  localparam logic [PW_W-1:0] PW_LAST  = PW_W'(POWERUP_CYCLES - 1);
  localparam logic [SL_W-1:0] SL_LAST  = SL_W'(SLOT_CYCLES - 1);
  localparam logic [SL_W-1:0] SL_HALF  = SL_W'(SLOT_CYCLES / 2);
  localparam logic [5:0]      COL_LAST = 6'(COLS - 1);
  localparam logic [7:0]      FUNC_CMD = (ROWS == 2) ? 8'h38 : 8'h30;

  typedef enum logic [2:0] {
    PWRUP, SET_FUNC, DISP_OFF, DISP_CLR, ENTRY, DISP_ON, ROW_ADDR, ROW_CHAR
  } state_t;

  state_t            state;
  logic [PW_W-1:0]   pwr_cnt;
  logic [SL_W-1:0]   slot_cnt;
  logic [SL_W-1:0]   slot_next;
  logic              row;
  logic              next_row;
  logic [5:0]        col;
  logic [5:0]        rd_col;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] fill_addr;
  logic [7:0]        rd_char;
  logic [7:0]        mem [0:(1 << ADDR_W) - 1];
  logic              wr_ok;

  assign slot_next = (slot_cnt == SL_LAST) ? '0 : slot_cnt + SL_W'(1);
  assign next_row  = (ROWS == 2) ? ~row : 1'b0;
  // The character read is the one for the slot about to be loaded.
  assign rd_col    = (state == ROW_CHAR) ? col + 6'd1 : 6'd0;
  assign rd_addr   = (row ? ADDR_W'(COLS) : '0) + ADDR_W'(rd_col);
  assign rd_char   = mem[rd_addr];
  assign wr_ok     = ready && wr_en && !clear && (32'(wr_addr) < DEPTH);

  // ready low means the 0x20 fill is walking the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready     <= 1'b0;
      fill_addr <= '0;
    end else if (!ready) begin
      if (fill_addr == ADDR_W'(DEPTH - 1)) begin
        ready     <= 1'b1;
        fill_addr <= '0;
      end else begin
        fill_addr <= fill_addr + ADDR_W'(1);
      end
    end else if (clear) begin
      ready <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!ready)
      mem[fill_addr] <= 8'h20;
    else if (wr_ok)
      mem[wr_addr] <= wr_char;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWRUP;
      pwr_cnt   <= '0;
      slot_cnt  <= '0;
      row       <= 1'b0;
      col       <= '0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      init_done <= 1'b0;
    end else if (state == PWRUP) begin
      if (pwr_cnt == PW_LAST) begin
        state    <= SET_FUNC;
        slot_cnt <= '0;
        lcd_e    <= 1'b1;
        lcd_rs   <= 1'b0;
        lcd_data <= FUNC_CMD;
      end else begin
        pwr_cnt <= pwr_cnt + PW_W'(1);
      end
    end else begin
      slot_cnt <= slot_next;
      lcd_e    <= (slot_next < SL_HALF);
      if (slot_cnt == SL_LAST) begin
        lcd_rs <= 1'b0;
        case (state)
          SET_FUNC: begin state <= DISP_OFF; lcd_data <= 8'h08; end
          DISP_OFF: begin state <= DISP_CLR; lcd_data <= 8'h01; end
          DISP_CLR: begin state <= ENTRY;    lcd_data <= 8'h06; end
          ENTRY:    begin state <= DISP_ON;  lcd_data <= 8'h0C; end
          DISP_ON: begin
            state     <= ROW_ADDR;
            row       <= 1'b0;
            lcd_data  <= 8'h80;
            init_done <= 1'b1;
          end
          ROW_ADDR: begin
            state    <= ROW_CHAR;
            col      <= '0;
            lcd_rs   <= 1'b1;
            lcd_data <= rd_char;
          end
          ROW_CHAR: begin
            if (col == COL_LAST) begin
              state    <= ROW_ADDR;
              row      <= next_row;
              lcd_data <= next_row ? 8'hC0 : 8'h80;
            end else begin
              col      <= col + 6'd1;
              lcd_rs   <= 1'b1;
              lcd_data <= rd_char;
            end
          end
          default: state <= PWRUP;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb/tb_lcd_text_ctrl.sv - self-checking bench for lcd_text_ctrl
// Cycle-level model of the display stream and buffer, plus literal checks of the init and refresh order.
module tb_lcd_text_ctrl;
  localparam int P = 10, S = 8, C = 4, R = 2, N = R * C, AW = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic wr_en = 1'b0, clear = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic ready, init_done, lcd_e, lcd_rs;
  logic [7:0] lcd_data;
  logic wr_en1 = 1'b0, clear1 = 1'b0;
  logic [1:0] wr_addr1 = '0;
  logic [7:0] wr_char1 = '0;
  logic ready1, init_done1, lcd_e1, lcd_rs1;
  logic [7:0] lcd_data1;

  int n_cmp = 0, n_err = 0, mt = 0;

  always #5 clk = ~clk;

  lcd_text_ctrl #(.POWERUP_CYCLES(P), .SLOT_CYCLES(S), .COLS(C), .ROWS(R), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .clear(clear),
    .ready(ready), .init_done(init_done), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_data(lcd_data));

  lcd_text_ctrl #(.POWERUP_CYCLES(P), .SLOT_CYCLES(S), .COLS(C), .ROWS(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_char(wr_char1), .clear(clear1),
    .ready(ready1), .init_done(init_done1), .lcd_e(lcd_e1), .lcd_rs(lcd_rs1), .lcd_data(lcd_data1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, mt);
    end
  endtask

  // Model state: cycle index since reset release, buffer contents, expected registered outputs.
  int t, fill_left;
  bit m_ready, e_rs, e_init, prev_e;
  logic [7:0] e_data;
  logic [7:0] m_buf [N];
  logic [7:0] init_cmd [5] = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  logic [7:0] cap_d[$];
  bit cap_rs[$];
  int cap_t[$];

  task automatic slot_content(input int k, output bit rs, output logic [7:0] d);
    int j, r, c;
    if (k < 5) begin
      rs = 1'b0;
      d  = init_cmd[k];
    end else begin
      j = (k - 5) % (R * (C + 1));
      r = j / (C + 1);
      c = j % (C + 1);
      if (c == 0) begin
        rs = 1'b0;
        d  = (r == 1) ? 8'hC0 : 8'h80;
      end else begin
        rs = 1'b1;
        d  = m_buf[r * C + c - 1];
      end
    end
  endtask

  always @(negedge clk) begin
    int k;
    if (rst) begin
      t = 0; fill_left = N; m_ready = 1'b0;
      e_rs = 1'b0; e_data = 8'h00; e_init = 1'b0; prev_e = 1'b0;
    end else begin
      check("lcd_e", lcd_e, (t >= P) && (((t - P) % S) < S / 2));
      check("lcd_rs", lcd_rs, e_rs);
      check("lcd_data", lcd_data, e_data);
      check("init_done", init_done, e_init);
      check("ready", ready, m_ready);
      if (prev_e && !lcd_e) begin
        cap_d.push_back(lcd_data); cap_rs.push_back(lcd_rs); cap_t.push_back(t);
      end
      prev_e = lcd_e;
      if (t == P - 1 || (t >= P && (t - P) % S == S - 1)) begin
        k = (t + 1 - P) / S;
        slot_content(k, e_rs, e_data);
        if (k == 5) e_init = 1'b1;
      end
      if (!m_ready) begin
        m_buf[N - fill_left] = 8'h20;
        fill_left--;
        if (fill_left == 0) m_ready = 1'b1;
      end else if (clear) begin
        fill_left = N;
        m_ready = 1'b0;
      end else if (wr_en && int'(wr_addr) < N) begin
        m_buf[int'(wr_addr)] = wr_char;
      end
      t++;
    end
  end

  int t1;
  bit prev1;
  logic [7:0] cap1_d[$];
  bit cap1_rs[$];
  int cap1_t[$];

  always @(negedge clk) begin
    if (rst) begin
      t1 = 0; prev1 = 1'b0;
    end else begin
      if (prev1 && !lcd_e1) begin
        cap1_d.push_back(lcd_data1); cap1_rs.push_back(lcd_rs1); cap1_t.push_back(t1);
      end
      prev1 = lcd_e1;
      t1++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    mt++;
  endtask

  task automatic goto_cycle(input int c);
    while (mt < c) step();
  endtask

  task automatic check_pass(input int after, input string tag,
                            input logic [7:0] exp_d [9], input bit exp_rs [9]);
    int i0 = -1;
    for (int i = 0; i < cap_d.size(); i++)
      if (i0 < 0 && cap_t[i] > after && cap_d[i] == 8'h80 && cap_rs[i] == 1'b0) i0 = i;
    if (i0 < 0 || i0 + 9 >= cap_d.size()) begin
      check({tag, " pass captured"}, 0, 1);
    end else begin
      for (int j = 0; j < 9; j++) begin
        check($sformatf("%s data[%0d]", tag, j), cap_d[i0 + 1 + j], exp_d[j]);
        check($sformatf("%s rs[%0d]", tag, j), cap_rs[i0 + 1 + j], exp_rs[j]);
      end
    end
  endtask

  initial begin
    logic [7:0] lit_d [16];
    logic [7:0] lit1_d [16];
    bit lit_rs [16];
    logic [7:0] pass_wr [9];
    logic [7:0] pass_clr [9];
    bit pass_rs [9];
    int wt, cnt, sz, n_c0;
    bit found;

    lit_d    = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C, 8'h80, 8'h20, 8'h20,
                 8'h20, 8'h20, 8'hC0, 8'h20, 8'h20, 8'h20, 8'h20, 8'h80};
    lit1_d   = '{8'h30, 8'h08, 8'h01, 8'h06, 8'h0C, 8'h80, 8'h20, 8'h20,
                 8'h20, 8'h20, 8'h80, 8'h20, 8'h20, 8'h20, 8'h20, 8'h80};
    lit_rs   = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    pass_wr  = '{8'h44, 8'h4F, 8'h20, 8'h20, 8'hC0, 8'h20, 8'h48, 8'h20, 8'h20};
    pass_clr = '{8'h20, 8'h20, 8'h20, 8'h20, 8'hC0, 8'h20, 8'h20, 8'h20, 8'h20};
    pass_rs  = '{1, 1, 1, 1, 0, 1, 1, 1, 1};

    // Reset state
    @(posedge clk); #2;
    check("rst lcd_e", lcd_e, 0);
    check("rst lcd_rs", lcd_rs, 0);
    check("rst lcd_data", lcd_data, 0);
    check("rst ready", ready, 0);
    check("rst init_done", init_done, 0);
    @(posedge clk); #1; rst = 1'b0; #1; mt = 0;

    for (int i = 0; i < P; i++) begin
      goto_cycle(i);
      check($sformatf("pwrup lcd_e c%0d", i), lcd_e, 0);
      if (i == 7) check("ready c7", ready, 0);
      if (i == 8) check("ready c8", ready, 1);
    end
    goto_cycle(10);
    check("first rise lcd_e", lcd_e, 1);
    check("first rise rs", lcd_rs, 0);
    check("first rise data", lcd_data, 8'h38);
    goto_cycle(13); check("lcd_e c13", lcd_e, 1);
    goto_cycle(14); check("first fall c14", lcd_e, 0);
    goto_cycle(49); check("init_done c49", init_done, 0);
    goto_cycle(50); check("init_done c50", init_done, 1);

    goto_cycle(150);
    check("init captures", cap_d.size() >= 16, 1);
    check("rows1 captures", cap1_d.size() >= 16, 1);
    for (int i = 0; i < 16; i++) begin
      if (i < cap_d.size()) begin
        check($sformatf("init seq data[%0d]", i), cap_d[i], lit_d[i]);
        check($sformatf("init seq rs[%0d]", i), cap_rs[i], lit_rs[i]);
      end
      if (i < cap1_d.size()) begin
        check($sformatf("rows1 seq data[%0d]", i), cap1_d[i], lit1_d[i]);
        check($sformatf("rows1 seq rs[%0d]", i), cap1_rs[i], lit_rs[i]);
      end
    end
    if (cap1_t.size() > 10) check("rows1 refresh period", cap1_t[10] - cap1_t[5], 5 * S);

    // Writes, including one to an out-of-range address
    wr_en = 1'b1; wr_addr = 4'd0; wr_char = 8'h44; step();
    wr_addr = 4'd1; wr_char = 8'h4F; step();
    wr_addr = 4'd5; wr_char = 8'h48; step();
    wr_addr = 4'd9; wr_char = 8'h51; step();
    wr_en = 1'b0;
    wt = mt;
    goto_cycle(wt + 200);
    check_pass(wt + 10, "write", pass_wr, pass_rs);

    // Clear and write together; writes during the fill are ignored
    clear = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_char = 8'h58; step();
    clear = 1'b0; wr_addr = 4'd2; wr_char = 8'h5A;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == 3) wr_en = 1'b0;
      step();
    end
    wr_en = 1'b0;
    check("clear ready low cycles", cnt, N);
    wt = mt;
    goto_cycle(wt + 200);
    check_pass(wt + 10, "clear", pass_clr, pass_rs);

    // Reset in the middle of a character slot
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (lcd_e === 1'b1 && lcd_rs === 1'b1) found = 1'b1;
    end
    check("midslot slot found", found, 1);
    sz = cap_d.size();
    #1; rst = 1'b1; #1;
    check("midrst lcd_e", lcd_e, 0);
    check("midrst lcd_rs", lcd_rs, 0);
    check("midrst lcd_data", lcd_data, 0);
    check("midrst init_done", init_done, 0);
    check("midrst ready", ready, 0);
    @(posedge clk); @(posedge clk); #1; rst = 1'b0; #1; mt = 0;
    goto_cycle(7); check("restart ready c7", ready, 0);
    goto_cycle(8); check("restart ready c8", ready, 1);
    goto_cycle(10); check("restart data c10", lcd_data, 8'h38);
    goto_cycle(15);
    check("restart captures", cap_d.size(), sz + 1);
    if (cap_d.size() > sz) check("restart first cmd", cap_d[sz], 8'h38);
    goto_cycle(60);
    check("restart init_done", init_done, 1);

    n_c0 = 0;
    foreach (cap1_d[i]) if (cap1_d[i] == 8'hC0) n_c0++;
    check("rows1 no 0xC0", n_c0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
